rk4_step_scheduler: RTL and testbench
=====================================

// Module: rk4_step_scheduler
// PURPOSE
//  Sequences one RK4 integration step per tick from the divided step clock: issues k1..k4 evaluations
//  to the shared f(t,y) datapath, then the weighted accumulate and the y/t commit. Counts steps up to a
//  programmed total, flags tick overruns and stalled evaluations. Sits between the divider and the RK4 datapath.
// PARAMETERS
//  STEP_W      16   width of num_steps / step_count
//  TIMEOUT_MAX 8'd200  max cycles in WAIT before timeout fault (8-bit counter)
// PORTS
//  clk_in      in   1       system clock, all logic on posedge
//  reset       in   1       asynchronous, active-high; clears all state and outputs
//  start       in   1       begin run; honoured only in IDLE or FAULT
//  abort       in   1       force IDLE next edge from any state
//  num_steps   in   STEP_W  steps to run; sampled on accepted start
//  tick        in   1       1-cycle step pulse (synchronised divider edge)
//  f_done      in   1       datapath evaluation complete
//  f_start     out  1       1-cycle pulse: launch evaluation of current stage
//  stage       out  2       k index 0..3 (k1..k4)
//  h_sel       out  2       argument offset: 0=y_n, 1=y_n+h/2*k_prev, 2=y_n+h*k_prev
//  acc_weight  out  2       0=x1, 1=x2 (k1,k4 -> x1; k2,k3 -> x2)
//  acc_en      out  1       1-cycle pulse: accumulate weight*k_stage
//  y_update    out  1       1-cycle pulse: y += h/6*acc, t += h, clear acc
//  busy        out  1       high in every state except IDLE and FAULT
//  run_done    out  1       1-cycle pulse at end of run
//  step_count  out  STEP_W  completed steps this run
//  overrun     out  1       sticky: tick arrived outside ARMED during a run
//  timeout_err out  1       sticky: WAIT exceeded TIMEOUT_MAX
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; internal num_steps/timer 0. All outputs registered.
//  FSM: IDLE, ARMED, ISSUE, WAIT, ACC, UPDATE, FAULT.
//  IDLE: start & num_steps!=0 -> ARMED, latch num_steps, step_count=0, clear overrun/timeout_err.
//        start & num_steps==0 -> stay IDLE, run_done pulse next cycle.
//  ARMED: tick -> ISSUE, stage=0. Else hold.
//  ISSUE: f_start=1 this cycle (exactly one cycle); -> WAIT, timer=0. f_done here ignored.
//  WAIT: f_done -> ACC. Else timer+1; timer==TIMEOUT_MAX -> FAULT, timeout_err=1.
//  ACC: acc_en=1 one cycle; stage<3 -> ISSUE, stage+1; stage==3 -> UPDATE.
//  UPDATE: y_update=1 one cycle; step_count+1; if new count==num_steps -> IDLE, run_done pulse
//          (same cycle step_count shows final value); else -> ARMED.
//  FAULT: outputs idle, busy=0; start -> ARMED as from IDLE. tick ignored, no overrun.
//  h_sel/acc_weight are pure decodes of stage: stage0 h_sel=0, 1-2 h_sel=1, 3 h_sel=2;
//    acc_weight=1 for stage 1,2 else 0. Valid while busy; held at 0 in IDLE/FAULT.
//  tick while busy & not ARMED: dropped, overrun=1 (sticky until next accepted start or reset).
//  tick in IDLE: ignored. f_done outside WAIT: ignored.
//  Simultaneous tick+f_done: each handled per its own rule in that cycle.
//  abort (priority over all): -> IDLE next edge; pulses 0; step_count and sticky flags held; no run_done.
//  start while busy: ignored. reset mid-step: immediate return to reset values, no y_update.
//  Min step latency tick->y_update: 1 + 4*(ISSUE+WAIT+ACC) = 13 cycles with f_done immediate.
//  step_count saturates never: ends at num_steps (max 2^STEP_W-1).
// STRUCTURE
//  rk4_pkg: state enum rk4_sched_state_t, STAGE_K1..K4, HSEL_NONE/HALF/FULL, WEIGHT_X1/X2 constants.
//  Sub-module rk4_wait_timer: 8-bit clear/increment counter with expire flag == TIMEOUT_MAX.
// TESTING
//  num_steps=2, start, ticks every 100 clk, f_done 3 clk after f_start -> 8 f_start, stage 0,1,2,3 x2,
//    h_sel 0,1,1,2, acc_weight 0,1,1,0, 2 y_update, run_done once, step_count=2, busy then 0.
//  f_done same cycle as f_start -> ignored; f_done later in WAIT -> single acc_en; step latency 13 clk min.
//  Extra tick mid-step (in WAIT) -> overrun=1, step unaffected; next start clears overrun.
//  f_done withheld -> timeout_err=1 after 200 WAIT cycles, FAULT, busy=0; start then resumes a new run.
//  abort in WAIT at stage 2 -> IDLE next edge, no acc_en/y_update, no run_done; step_count held.
//  start with num_steps=0 -> run_done pulse, no f_start; reset asserted in ACC -> all outputs 0 same cycle.

Source files
------------

// File: rtl/rk4_step_scheduler_pkg.sv
// rk4_step_scheduler_pkg: FSM state type, stage/offset/weight codes and stage decodes for the RK4 step scheduler
package rk4_step_scheduler_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_ISSUE, S_WAIT, S_ACC, S_UPDATE, S_FAULT
  } rk4_sched_state_t;
  localparam logic [1:0] STAGE_K1 = 2'd0;
  localparam logic [1:0] STAGE_K2 = 2'd1;
  localparam logic [1:0] STAGE_K3 = 2'd2;
  localparam logic [1:0] STAGE_K4 = 2'd3;
  localparam logic [1:0] HSEL_NONE = 2'd0;
  localparam logic [1:0] HSEL_HALF = 2'd1;
  localparam logic [1:0] HSEL_FULL = 2'd2;
  localparam logic [1:0] WEIGHT_X1 = 2'd0;
  localparam logic [1:0] WEIGHT_X2 = 2'd1;
  localparam logic [7:0] TIMEOUT_MAX_DEF = 8'd200;
  function automatic logic [1:0] hsel_of(input logic [1:0] s);
    return s == STAGE_K1 ? HSEL_NONE : s == STAGE_K4 ? HSEL_FULL : HSEL_HALF;
  endfunction
  function automatic logic [1:0] weight_of(input logic [1:0] s);
    return (s == STAGE_K2 || s == STAGE_K3) ? WEIGHT_X2 : WEIGHT_X1;
  endfunction
endpackage

// File: rtl/rk4_step_scheduler_if.sv
// rk4_step_scheduler_if: scheduler <-> f(t,y) datapath link; master = scheduler (drives launch/stage/accumulate/commit), slave = datapath (returns f_done)
interface rk4_step_scheduler_if;
  logic f_start;
  logic f_done;
  logic [1:0] stage;
  logic [1:0] h_sel;
  logic [1:0] acc_weight;
  logic acc_en;
  logic y_update;
  modport master(output f_start, stage, h_sel, acc_weight, acc_en, y_update, input f_done);
  modport slave(input f_start, stage, h_sel, acc_weight, acc_en, y_update, output f_done);
endinterface

// File: rtl/rk4_step_scheduler_wait_timer.sv
// rk4_step_scheduler_wait_timer: 8-bit clear/increment counter; ports clk_in, reset, clr, inc in, expire out (count == TIMEOUT_MAX)
module rk4_step_scheduler_wait_timer
  import rk4_step_scheduler_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  logic [7:0] cnt;
  always_ff @(posedge clk_in or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign expire = cnt == TIMEOUT_MAX;
endmodule

// File: rtl/rk4_step_scheduler.sv
// rk4_step_scheduler: per tick, issues k1..k4 evaluations, accumulates, commits y/t; counts steps, flags overrun and WAIT timeout.
// Ports: clk_in, reset (async high), start, abort, num_steps, tick in; dp (datapath master modport);
// busy, run_done, step_count, overrun, timeout_err out. All outputs registered.
module rk4_step_scheduler
  import rk4_step_scheduler_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter logic [7:0] TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
  input  logic clk_in,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic tick,
  rk4_step_scheduler_if.master dp,
  output logic busy,
  output logic run_done,
  output logic [STEP_W-1:0] step_count,
  output logic overrun,
  output logic timeout_err
);
  rk4_sched_state_t state;
  logic [STEP_W-1:0] n_steps;
  logic [STEP_W-1:0] next_count;
  logic expire;
  assign next_count = step_count + 1'b1;
  // timer restarts during ISSUE so WAIT always begins counting from zero
  rk4_step_scheduler_wait_timer #(.TIMEOUT_MAX(TIMEOUT_MAX)) u_timer (
    .clk_in(clk_in),
    .reset(reset),
    .clr(state == S_ISSUE),
    .inc(state == S_WAIT && !dp.f_done),
    .expire(expire)
  );
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      n_steps <= '0;
      step_count <= '0;
      busy <= 1'b0;
      run_done <= 1'b0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
      dp.f_start <= 1'b0;
      dp.acc_en <= 1'b0;
      dp.y_update <= 1'b0;
      dp.stage <= STAGE_K1;
      dp.h_sel <= HSEL_NONE;
      dp.acc_weight <= WEIGHT_X1;
    end else begin
      dp.f_start <= 1'b0;
      dp.acc_en <= 1'b0;
      dp.y_update <= 1'b0;
      run_done <= 1'b0;
      // a tick landing mid-step is dropped but remembered
      if (!abort && tick && state inside {S_ISSUE, S_WAIT, S_ACC, S_UPDATE}) overrun <= 1'b1;
      if (abort) begin
        state <= S_IDLE;
        busy <= 1'b0;
        dp.stage <= STAGE_K1;
        dp.h_sel <= HSEL_NONE;
        dp.acc_weight <= WEIGHT_X1;
      end else
        case (state)
          S_IDLE, S_FAULT:
            if (start && num_steps != '0) begin
              state <= S_ARMED;
              busy <= 1'b1;
              n_steps <= num_steps;
              step_count <= '0;
              overrun <= 1'b0;
              timeout_err <= 1'b0;
              dp.stage <= STAGE_K1;
              dp.h_sel <= hsel_of(STAGE_K1);
              dp.acc_weight <= weight_of(STAGE_K1);
            end else if (start) begin
              state <= S_IDLE;
              run_done <= 1'b1;
            end
          S_ARMED:
            if (tick) begin
              state <= S_ISSUE;
              dp.f_start <= 1'b1;
              dp.stage <= STAGE_K1;
              dp.h_sel <= hsel_of(STAGE_K1);
              dp.acc_weight <= weight_of(STAGE_K1);
            end
          S_ISSUE: state <= S_WAIT;
          S_WAIT:
            if (dp.f_done) begin
              state <= S_ACC;
              dp.acc_en <= 1'b1;
            end else if (expire) begin
              state <= S_FAULT;
              busy <= 1'b0;
              timeout_err <= 1'b1;
              dp.stage <= STAGE_K1;
              dp.h_sel <= HSEL_NONE;
              dp.acc_weight <= WEIGHT_X1;
            end
          S_ACC:
            if (dp.stage == STAGE_K4) begin
              state <= S_UPDATE;
              dp.y_update <= 1'b1;
            end else begin
              state <= S_ISSUE;
              dp.f_start <= 1'b1;
              dp.stage <= dp.stage + 2'd1;
              dp.h_sel <= hsel_of(dp.stage + 2'd1);
              dp.acc_weight <= weight_of(dp.stage + 2'd1);
            end
          S_UPDATE: begin
            step_count <= next_count;
            if (next_count == n_steps) begin
              state <= S_IDLE;
              busy <= 1'b0;
              run_done <= 1'b1;
              dp.stage <= STAGE_K1;
              dp.h_sel <= HSEL_NONE;
              dp.acc_weight <= WEIGHT_X1;
            end else state <= S_ARMED;
          end
          default: state <= S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_rk4_step_scheduler.sv
// tb_rk4_step_scheduler: randomized RK4 scheduler bench against a stage-table / latency reference model
module tb_rk4_step_scheduler;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic tick = 1'b0;
  logic [15:0] num_steps = '0;
  logic busy, run_done, overrun, timeout_err;
  logic [15:0] step_count;
  rk4_step_scheduler_if ifc();
  rk4_step_scheduler #(.STEP_W(16), .TIMEOUT_MAX(8'd200)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .start(start),
    .abort(abort),
    .num_steps(num_steps),
    .tick(tick),
    .dp(ifc.master),
    .busy(busy),
    .run_done(run_done),
    .step_count(step_count),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );
  always #5 clk_in = ~clk_in;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic auto_resp = 1'b1;
  logic dbl = 1'b0;
  int fixed_d = 0;
  int done_at = -1;
  int issue_at = -1;
  int hsel_ref[4] = '{0, 1, 1, 2};
  int w_ref[4] = '{0, 1, 1, 0};
  int fs_stage[$], fs_hsel[$], acc_stage[$], acc_w[$], yu_cyc[$], rd_cyc[$], rd_cnt[$], tick_cyc[$], dq[$];
  task automatic clear_logs();
    fs_stage.delete(); fs_hsel.delete(); acc_stage.delete(); acc_w.delete();
    yu_cyc.delete(); rd_cyc.delete(); rd_cnt.delete(); tick_cyc.delete(); dq.delete();
  endtask
  // one clock: observe outputs of the new cycle, then drive the datapath response for it
  task automatic clk_step();
    int d;
    @(posedge clk_in);
    #1;
    cyc++;
    if (ifc.f_start) begin
      d = fixed_d != 0 ? fixed_d : int'($urandom_range(4, 1));
      dq.push_back(d);
      issue_at = cyc;
      done_at = cyc + d;
      fs_stage.push_back(int'(ifc.stage));
      fs_hsel.push_back(int'(ifc.h_sel));
    end
    if (ifc.acc_en) begin
      acc_stage.push_back(int'(ifc.stage));
      acc_w.push_back(int'(ifc.acc_weight));
    end
    if (ifc.y_update) yu_cyc.push_back(cyc);
    if (run_done) begin
      rd_cyc.push_back(cyc);
      rd_cnt.push_back(int'(step_count));
    end
    ifc.f_done = auto_resp && (cyc == done_at || (dbl && cyc == issue_at));
  endtask
  task automatic do_tick();
    tick_cyc.push_back(cyc);
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
  endtask
  task automatic begin_run(input int n);
    num_steps = 16'(n);
    start = 1'b1;
    clk_step();
    start = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if ({busy, run_done, step_count, overrun, timeout_err, ifc.f_start, ifc.stage, ifc.h_sel,
         ifc.acc_weight, ifc.acc_en, ifc.y_update} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b rd=%b cnt=%0d ov=%b to=%b fs=%b st=%0d hs=%0d w=%0d acc=%b yu=%b want all 0",
               busy, run_done, step_count, overrun, timeout_err, ifc.f_start, ifc.stage, ifc.h_sel,
               ifc.acc_weight, ifc.acc_en, ifc.y_update);
    end
    reset = 1'b0;
    clk_step();
  endtask
  task automatic test_random_runs();
    for (int r = 0; r < 4; r++) begin
      int n;
      int lat;
      int exp_lat;
      n = int'($urandom_range(3, 1));
      clear_logs();
      fixed_d = 0;
      begin_run(n);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL run%0d busy_after_start got %b want 1", r, busy); end
      repeat (n) begin do_tick(); repeat (99) clk_step(); end
      checks++;
      if (fs_stage.size() != 4 * n || acc_stage.size() != 4 * n) begin
        errors++;
        $display("FAIL run%0d eval_count got f_start=%0d acc_en=%0d want %0d", r, fs_stage.size(), acc_stage.size(), 4 * n);
      end
      for (int i = 0; i < fs_stage.size(); i++) begin
        checks++;
        if (fs_stage[i] != i % 4 || fs_hsel[i] != hsel_ref[i % 4]) begin
          errors++;
          $display("FAIL run%0d issue%0d got stage=%0d h_sel=%0d want stage=%0d h_sel=%0d", r, i, fs_stage[i], fs_hsel[i], i % 4, hsel_ref[i % 4]);
        end
      end
      for (int i = 0; i < acc_stage.size(); i++) begin
        checks++;
        if (acc_stage[i] != i % 4 || acc_w[i] != w_ref[i % 4]) begin
          errors++;
          $display("FAIL run%0d acc%0d got stage=%0d weight=%0d want stage=%0d weight=%0d", r, i, acc_stage[i], acc_w[i], i % 4, w_ref[i % 4]);
        end
      end
      checks++;
      if (yu_cyc.size() != n) begin errors++; $display("FAIL run%0d y_update_count got %0d want %0d", r, yu_cyc.size(), n); end
      for (int s = 0; s < yu_cyc.size() && 4 * s + 3 < dq.size(); s++) begin
        exp_lat = 9;
        for (int k = 0; k < 4; k++) exp_lat += dq[4 * s + k];
        lat = yu_cyc[s] - tick_cyc[s];
        checks++;
        if (lat != exp_lat) begin errors++; $display("FAIL run%0d step%0d_latency got %0d want %0d", r, s, lat, exp_lat); end
      end
      checks++;
      if (rd_cyc.size() != 1 || yu_cyc.size() != n || rd_cyc[0] != yu_cyc[n - 1] + 1 || rd_cnt[0] != n) begin
        errors++;
        $display("FAIL run%0d run_done got pulses=%0d want 1 one cycle after last y_update with step_count=%0d", r, rd_cyc.size(), n);
      end
      checks++;
      if (step_count !== 16'(n) || busy !== 1'b0) begin
        errors++;
        $display("FAIL run%0d end_state got step_count=%0d busy=%b want %0d 0", r, step_count, busy, n);
      end
    end
  endtask
  task automatic test_fdone_timing();
    clear_logs();
    dbl = 1'b1;
    fixed_d = 2;
    begin_run(1);
    do_tick();
    repeat (40) clk_step();
    dbl = 1'b0;
    checks++;
    if (acc_stage.size() != 4 || fs_stage.size() != 4) begin
      errors++;
      $display("FAIL issue_fdone_ignored got acc_en=%0d f_start=%0d want 4 4", acc_stage.size(), fs_stage.size());
    end
    checks++;
    if (yu_cyc.size() != 1 || yu_cyc[0] - tick_cyc[0] != 17) begin
      errors++;
      $display("FAIL issue_fdone_latency got y_updates=%0d latency=%0d want 1 17", yu_cyc.size(), yu_cyc.size() ? yu_cyc[0] - tick_cyc[0] : -1);
    end
    clear_logs();
    fixed_d = 1;
    begin_run(1);
    do_tick();
    repeat (30) clk_step();
    checks++;
    if (yu_cyc.size() != 1 || yu_cyc[0] - tick_cyc[0] != 13) begin
      errors++;
      $display("FAIL min_latency got y_updates=%0d latency=%0d want 1 13", yu_cyc.size(), yu_cyc.size() ? yu_cyc[0] - tick_cyc[0] : -1);
    end
    fixed_d = 0;
  endtask
  task automatic test_overrun();
    clear_logs();
    fixed_d = 4;
    begin_run(2);
    do_tick();
    repeat (2) clk_step();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
    repeat (95) clk_step();
    checks++;
    if (fs_stage.size() != 4 || yu_cyc.size() != 1 || yu_cyc[0] - tick_cyc[0] != 25) begin
      errors++;
      $display("FAIL overrun_step_unaffected got f_start=%0d y_updates=%0d want 4 1 latency 25", fs_stage.size(), yu_cyc.size());
    end
    do_tick();
    repeat (99) clk_step();
    checks++;
    if (step_count !== 16'd2 || overrun !== 1'b1 || rd_cyc.size() != 1) begin
      errors++;
      $display("FAIL overrun_sticky got step_count=%0d overrun=%b run_done=%0d want 2 1 1", step_count, overrun, rd_cyc.size());
    end
    fixed_d = 0;
    begin_run(1);
    checks++;
    if (overrun !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_clear got overrun=%b busy=%b want 0 1", overrun, busy);
    end
    do_tick();
    repeat (40) clk_step();
  endtask
  task automatic test_timeout();
    int c;
    int waited;
    clear_logs();
    auto_resp = 1'b0;
    begin_run(1);
    do_tick();
    c = cyc;
    for (int i = 0; i < 300 && timeout_err !== 1'b1; i++) clk_step();
    waited = cyc - c - 1;
    checks++;
    if (timeout_err !== 1'b1 || waited < 200 || waited > 202) begin
      errors++;
      $display("FAIL timeout_window got timeout_err=%b wait_cycles=%0d want 1 about 200", timeout_err, waited);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    repeat (5) clk_step();
    checks++;
    if (overrun !== 1'b0 || fs_stage.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fault_tick_ignored got overrun=%b f_start=%0d busy=%b want 0 1 0", overrun, fs_stage.size(), busy);
    end
    auto_resp = 1'b1;
    begin_run(1);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fault_restart got timeout_err=%b busy=%b want 0 1", timeout_err, busy);
    end
    do_tick();
    repeat (40) clk_step();
    checks++;
    if (step_count !== 16'd1 || yu_cyc.size() != 1) begin
      errors++;
      $display("FAIL fault_resume_run got step_count=%0d y_updates=%0d want 1 1", step_count, yu_cyc.size());
    end
  endtask
  task automatic test_abort();
    clear_logs();
    fixed_d = 3;
    begin_run(3);
    do_tick();
    repeat (99) clk_step();
    do_tick();
    for (int i = 0; i < 50 && fs_stage.size() < 7; i++) clk_step();
    clk_step();
    abort = 1'b1;
    clk_step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || ifc.stage !== 2'd0 || ifc.h_sel !== 2'd0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b stage=%0d h_sel=%0d want 0 0 0", busy, ifc.stage, ifc.h_sel);
    end
    repeat (20) clk_step();
    checks++;
    if (acc_stage.size() != 6 || yu_cyc.size() != 1 || rd_cyc.size() != 0 || step_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_effects got acc_en=%0d y_updates=%0d run_done=%0d step_count=%0d want 6 1 0 1",
               acc_stage.size(), yu_cyc.size(), rd_cyc.size(), step_count);
    end
    fixed_d = 0;
  endtask
  task automatic test_zero_steps();
    clear_logs();
    begin_run(0);
    checks++;
    if (run_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_steps_done got run_done=%b busy=%b want 1 0", run_done, busy);
    end
    clk_step();
    checks++;
    if (run_done !== 1'b0) begin errors++; $display("FAIL zero_steps_pulse got %b want 0", run_done); end
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    repeat (10) clk_step();
    checks++;
    if (fs_stage.size() != 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got f_start=%0d overrun=%b want 0 0", fs_stage.size(), overrun);
    end
  endtask
  task automatic test_reset_in_acc();
    clear_logs();
    fixed_d = 2;
    begin_run(1);
    do_tick();
    for (int i = 0; i < 30 && acc_stage.size() == 0; i++) clk_step();
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, run_done, step_count, overrun, timeout_err, ifc.f_start, ifc.stage, ifc.h_sel,
         ifc.acc_weight, ifc.acc_en, ifc.y_update} !== '0) begin
      errors++;
      $display("FAIL reset_in_acc got busy=%b cnt=%0d acc=%b yu=%b fs=%b want all 0", busy, step_count, ifc.acc_en, ifc.y_update, ifc.f_start);
    end
    #2;
    reset = 1'b0;
    repeat (20) clk_step();
    checks++;
    if (yu_cyc.size() != 0 || busy !== 1'b0 || acc_stage.size() != 1) begin
      errors++;
      $display("FAIL reset_no_update got y_updates=%0d busy=%b acc_en=%0d want 0 0 1", yu_cyc.size(), busy, acc_stage.size());
    end
    fixed_d = 0;
  endtask
  initial begin
    ifc.f_done = 1'b0;
    test_reset();
    test_random_runs();
    test_fdone_timing();
    test_overrun();
    test_timeout();
    test_abort();
    test_zero_steps();
    test_reset_in_acc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
